// File: rtl/string_gen_1101.sv
// string_gen_1101
//   Serial pattern transmitter for the 1101 string detector. Words accepted
//   through a valid/ready handshake are shifted out MSB-first, one bit per
//   clock, with no gap between chained words. A reference copy of the 1101
//   detector tracks the emitted stream and flags and counts every match.
//
// Ports
//   CP          clock, rising edge
//   RST         synchronous reset, active low
//   LOAD_VALID  word offered on LOAD_DATA
//   LOAD_READY  word accepted this cycle (registered state only)
//   LOAD_DATA   word to send, MSB first
//   CLR         synchronous clear of the tracker and MATCH_CNT
//   D           serial bit stream (0 when idle)
//   D_VALID     D carries a payload bit
//   BUSY        a word is being shifted
//   DONE        last bit of a word is on D
//   MATCH       bit on D completes a 1101
//   MATCH_CNT   saturating match count
module string_gen_1101 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             CLR,
    output logic             D,
    output logic             D_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             MATCH,
    output logic [CNT_W-1:0] MATCH_CNT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Tracker encoding: S0=00, S1=01, S11=11, S110=10
    localparam logic [1:0] T_S0   = 2'b00;
    localparam logic [1:0] T_S1   = 2'b01;
    localparam logic [1:0] T_S11  = 2'b11;
    localparam logic [1:0] T_S110 = 2'b10;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [1:0]       trk;
    logic [1:0]       trk_nxt;
    logic             last_bit;
    logic             xfer;

    assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
    assign LOAD_READY = (state == IDLE) || last_bit;
    assign xfer       = LOAD_VALID && LOAD_READY;
    assign BUSY       = (state == SHIFT);
    assign D_VALID    = (state == SHIFT);
    assign D          = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
    assign DONE       = last_bit;
    assign MATCH      = D_VALID && (trk == T_S110) && D;

    // Shift FSM. A transfer is only possible when idle or on the last bit,
    // so it overrides the shift/decrement path.
    always_ff @(posedge CP) begin
        if (!RST) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (xfer) begin
            state   <= SHIFT;
            shreg   <= LOAD_DATA;
            bit_cnt <= LAST;
        end else if (state == SHIFT) begin
            if (bit_cnt != '0) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt - CW'(1);
            end else begin
                state <= IDLE;
            end
        end
    end

    always_comb begin
        trk_nxt = trk;
        case (trk)
            T_S0:    trk_nxt = D ? T_S1  : T_S0;
            T_S1:    trk_nxt = D ? T_S11 : T_S0;
            T_S11:   trk_nxt = D ? T_S11 : T_S110;
            default: trk_nxt = D ? T_S1  : T_S0;   // S110: 1 is a match, overlaps into S1
        endcase
    end

    // Tracker runs across word boundaries and idle gaps; only valid bits
    // advance it. CLR wins over both the update and a coincident match.
    always_ff @(posedge CP) begin
        if (!RST) begin
            trk       <= T_S0;
            MATCH_CNT <= '0;
        end else if (CLR) begin
            trk       <= T_S0;
            MATCH_CNT <= '0;
        end else if (D_VALID) begin
            trk <= trk_nxt;
            if (MATCH && (MATCH_CNT != '1))
                MATCH_CNT <= MATCH_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_string_gen_1101.sv
// Bench for string_gen_1101: a queue-based stream model plus a sliding-window
// 1101 matcher, checked every cycle against a CNT_W=8 and a CNT_W=2 instance,
// with literal per-scenario expectations from hand-computed bit sequences.
module tb_string_gen_1101;

    localparam int WIDTH = 8;

    logic CP = 1'b0;
    always #5 CP = ~CP;

    logic             RST = 1'b0;
    logic             LOAD_VALID = 1'b0;
    logic [WIDTH-1:0] LOAD_DATA = '0;
    logic             CLR = 1'b0;

    logic       LOAD_READY, D, D_VALID, BUSY, DONE, MATCH;
    logic [7:0] MATCH_CNT;
    logic       s_ready, s_d, s_dv, s_busy, s_done, s_match;
    logic [1:0] s_cnt;

    string_gen_1101 #(.WIDTH(WIDTH), .CNT_W(8)) dut (
        .CP(CP), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .LOAD_DATA(LOAD_DATA), .CLR(CLR), .D(D), .D_VALID(D_VALID), .BUSY(BUSY),
        .DONE(DONE), .MATCH(MATCH), .MATCH_CNT(MATCH_CNT)
    );

    string_gen_1101 #(.WIDTH(WIDTH), .CNT_W(2)) dut_s (
        .CP(CP), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(s_ready),
        .LOAD_DATA(LOAD_DATA), .CLR(CLR), .D(s_d), .D_VALID(s_dv), .BUSY(s_busy),
        .DONE(s_done), .MATCH(s_match), .MATCH_CNT(s_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bits still to be sent, oldest first; tracked history since clear.
    bit       q[$];
    int       n_hist = 0;
    bit [2:0] hist = '0;
    int       mcnt = 0;
    bit       chk_en = 1'b0;

    function automatic bit m_valid();
        return q.size() > 0;
    endfunction

    function automatic bit m_bit();
        return (q.size() > 0) ? q[0] : 1'b0;
    endfunction

    function automatic bit m_match();
        return m_valid() && (n_hist >= 3) && ({hist, m_bit()} == 4'b1101);
    endfunction

    always @(posedge CP) begin
        bit v, b, m, x;
        if (!RST) begin
            q.delete();
            n_hist = 0;
            hist   = '0;
            mcnt   = 0;
            chk_en = 1'b1;
        end else begin
            v = m_valid();
            b = m_bit();
            m = m_match();
            x = LOAD_VALID && (q.size() <= 1);
            if (CLR) begin
                n_hist = 0;
                hist   = '0;
                mcnt   = 0;
            end else if (v) begin
                if (m) mcnt++;
                hist = {hist[1:0], b};
                if (n_hist < 4) n_hist++;
            end
            if (v) void'(q.pop_front());
            if (x) for (int i = WIDTH - 1; i >= 0; i--) q.push_back(LOAD_DATA[i]);
        end
    end

    always @(negedge CP) begin
        if (chk_en) begin
            chk("ready",   {31'd0, LOAD_READY}, {31'd0, q.size() <= 1});
            chk("d",       {31'd0, D},          {31'd0, m_bit()});
            chk("d_valid", {31'd0, D_VALID},    {31'd0, m_valid()});
            chk("busy",    {31'd0, BUSY},       {31'd0, m_valid()});
            chk("done",    {31'd0, DONE},       {31'd0, q.size() == 1});
            chk("match",   {31'd0, MATCH},      {31'd0, m_match()});
            chk("cnt8",    {24'd0, MATCH_CNT},  (mcnt > 255) ? 32'd255 : 32'(mcnt));
            chk("cnt2",    {30'd0, s_cnt},      (mcnt > 3) ? 32'd3 : 32'(mcnt));
            chk("s_match", {31'd0, s_match},    {31'd0, m_match()});
        end
    end

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    logic [7:0]  dv8, mv8, dn8;
    logic [15:0] v16, m16;
    logic        any_done;

    initial begin
        // Reset
        RST = 1'b0;
        step(); step();
        @(negedge CP);
        chk("rst_ready", {31'd0, LOAD_READY}, 32'd1);
        chk("rst_dv",    {31'd0, D_VALID},    32'd0);
        chk("rst_d",     {31'd0, D},          32'd0);
        chk("rst_done",  {31'd0, DONE},       32'd0);
        chk("rst_cnt",   {24'd0, MATCH_CNT},  32'd0);

        // Single word 0xDA
        RST = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 8'hDA;
        step(); LOAD_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CP);
            dv8[7-i] = D; mv8[7-i] = MATCH; dn8[7-i] = DONE;
            step();
        end
        @(negedge CP);
        chk("single_d",     {24'd0, dv8},       32'hDA);
        chk("single_match", {24'd0, mv8},       32'h12);
        chk("single_done",  {24'd0, dn8},       32'h01);
        chk("single_cnt",   {24'd0, MATCH_CNT}, 32'd2);

        // Chained 0x0D, 0xB0
        CLR = 1'b1; step(); CLR = 1'b0;
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h0D;
        step(); LOAD_DATA = 8'hB0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CP);
            v16[15-i] = D_VALID; m16[15-i] = MATCH;
            step();
            if (i == 7) LOAD_VALID = 1'b0;
        end
        @(negedge CP);
        chk("chain_dv",    {16'd0, v16},       32'hFFFF);
        chk("chain_match", {16'd0, m16},       32'h0120);
        chk("chain_cnt",   {24'd0, MATCH_CNT}, 32'd2);
        chk("chain_end",   {31'd0, D_VALID},   32'd0);

        // 0xFF, 3 idle cycles, 0x00
        CLR = 1'b1; step(); CLR = 1'b0;
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hFF;
        step(); LOAD_VALID = 1'b0;
        repeat (8) step();
        for (int g = 0; g < 3; g++) begin
            @(negedge CP);
            chk("gap_ready", {31'd0, LOAD_READY}, 32'd1);
            chk("gap_d",     {31'd0, D},          32'd0);
            if (g == 2) begin LOAD_VALID = 1'b1; LOAD_DATA = 8'h00; end
            step();
        end
        LOAD_VALID = 1'b0;
        repeat (8) step();
        @(negedge CP);
        chk("gap_cnt", {24'd0, MATCH_CNT}, 32'd0);

        // Reset in cycle 5 of a word
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hDA;
        step(); LOAD_VALID = 1'b0;
        repeat (4) step();
        RST = 1'b0;
        step();
        RST = 1'b1;
        @(negedge CP);
        chk("mrst_dv",    {31'd0, D_VALID},    32'd0);
        chk("mrst_ready", {31'd0, LOAD_READY}, 32'd1);
        chk("mrst_cnt",   {24'd0, MATCH_CNT},  32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge CP);
            any_done |= DONE;
        end
        chk("mrst_nodone", {31'd0, any_done}, 32'd0);

        // CLR during the first match cycle of 0xDA
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hDA;
        step(); LOAD_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CP);
            mv8[7-i] = MATCH;
            if (i == 4) chk("clr_cnt_after", {24'd0, MATCH_CNT}, 32'd0);
            step();
            if (i == 2) CLR = 1'b1;
            if (i == 3) CLR = 1'b0;
        end
        @(negedge CP);
        chk("clr_match", {24'd0, mv8},       32'h10);
        chk("clr_cnt",   {24'd0, MATCH_CNT}, 32'd0);

        // Saturation: 0xDB, 0x6D chained
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hDB;
        step(); LOAD_DATA = 8'h6D;
        for (int i = 0; i < 16; i++) begin
            @(negedge CP);
            m16[15-i] = MATCH;
            step();
            if (i == 7) LOAD_VALID = 1'b0;
        end
        @(negedge CP);
        chk("sat_match", {16'd0, m16},       32'h1249);
        chk("sat_cnt2",  {30'd0, s_cnt},     32'd3);
        chk("sat_cnt8",  {24'd0, MATCH_CNT}, 32'd5);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/string_gen_1101.md
# string_gen_1101

Serial pattern transmitter that feeds the 1101 string detector. It takes parallel words through a valid/ready load handshake and shifts each one out MSB-first on a single-bit stream, one bit per clock, with no gap between back-to-back words. It also keeps an on-line reference copy of the 1101 detector state machine, so every emitted match is flagged and counted. Verification compares these flags and counts against the detector's `Q`.

## Interface

Parameters:
- `WIDTH`, 8: bits per loaded word; must be ≥ 2.
- `CNT_W`, 8: width of the match counter.

Ports:
- `CP` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous and active-low.
- `LOAD_VALID` in 1: a word is offered on `LOAD_DATA`.
- `LOAD_READY` out 1: the block accepts a word this cycle.
- `LOAD_DATA` in `WIDTH`: word to transmit, MSB sent first.
- `CLR` in 1: synchronous clear of the pattern tracker and `MATCH_CNT`.
- `D` out 1: serial bit stream, connects to the detector's `D`.
- `D_VALID` out 1: `D` carries a payload bit this cycle.
- `BUSY` out 1: a word is being shifted.
- `DONE` out 1: high during the cycle the last bit of a word is on `D`.
- `MATCH` out 1: the bit on `D` this cycle completes a 1101.
- `MATCH_CNT` out `CNT_W`: number of matches emitted, saturating.

## Operation

- **Handshake:** a transfer occurs on a rising edge where `LOAD_VALID & LOAD_READY` is high. `LOAD_DATA` is captured into the shift register, and the bit counter is loaded with `WIDTH-1`.
- **FSM states:**
  - IDLE to SHIFT on a transfer.
  - SHIFT stays in SHIFT while the counter is nonzero; the register shifts left and the counter decrements.
  - SHIFT with counter = 0 goes to SHIFT on a transfer in that cycle (chained word) and otherwise to IDLE.
- **Output decodes:**
  - `LOAD_READY` = IDLE, or (SHIFT and counter = 0).
  - `BUSY` = `D_VALID` = (state == SHIFT).
  - `D` = shift register MSB while in SHIFT; `D` = 0 in IDLE.
  - `DONE` = SHIFT and counter = 0.
- **Pattern tracker:** a 2-bit state with encoding S0 = 00, S1 = 01, S11 = 11, S110 = 10. It advances only on cycles where `D_VALID` is high:
  - From S0: a 1 goes to S1, a 0 stays in S0.
  - From S1: a 1 goes to S11, a 0 goes to S0.
  - From S11: a 1 stays in S11, a 0 goes to S110.
  - From S110: a 1 goes to S1 (this is a match), a 0 goes to S0.
- **Overlap:** the final 1 of a match may start the next pattern, so 1101101 yields two matches.
- **Stream continuity:** the tracker is not reset between words or during idle gaps. A pattern may straddle a word boundary.
- **`MATCH` and counter:**
  - `MATCH` = `D_VALID` & (tracker == S110) & `D`.
  - `MATCH_CNT` increments on each `MATCH` and saturates at 2^`CNT_W`−1 with no wrap-around.
- **CLR:** on the next edge, the tracker goes to S0 and `MATCH_CNT` goes to 0. `CLR` has priority over a simultaneous match and over a tracker update; the bit on `D` in that cycle is not tracked. `CLR` does not affect the shift FSM or the handshake.
- **Reset:** while `RST` = 0 at an edge, the block goes to IDLE. The shift register, bit counter, tracker and `MATCH_CNT` all clear to 0. Any load is ignored and a word in flight is discarded with no `DONE`.
- **Output values after reset:**
  - `LOAD_READY` = 1.
  - `D`, `D_VALID`, `BUSY`, `DONE`, `MATCH` = 0.
  - `MATCH_CNT` = 0.

## Timing

- **Accept to first bit:** a word accepted at edge k has its MSB on `D` in cycle k+1 and its LSB in cycle k+`WIDTH`. `DONE` is high in cycle k+`WIDTH`.
- **Chaining:** a transfer during the `DONE` cycle puts the new MSB on `D` in the very next cycle. The gap is zero and `D_VALID` stays high continuously.
- **Idle turnaround:** without chaining, `D_VALID` falls in the cycle after `DONE`, and the next accepted word begins one cycle after its acceptance edge.
- **`MATCH` timing:** `MATCH` is combinational, in the same cycle as the completing bit. The detector's registered `Q` rises one `CP` later. `MATCH_CNT` reflects a match from the following edge.
- **Combinational paths:** `LOAD_READY` depends only on registered state, never on `LOAD_VALID`.

## Test plan

- **Single word:** reset, then load 0xDA (`WIDTH` = 8) → `D` = 1,1,0,1,1,0,1,0 in cycles 1–8. `MATCH` is high in cycles 4 and 7. `DONE` is high in cycle 8. `MATCH_CNT` = 2, and the detector's `Q` is high in cycles 5 and 8.
- **Chained words:** 0x0D then 0xB0, with `LOAD_VALID` held → 16 contiguous `D_VALID` cycles. `MATCH` is high in cycles 8 and 11, the second straddling the word boundary. `MATCH_CNT` = 2.
- **No-match words with idle gap:** load 0xFF, idle 3 cycles, load 0x00 → `MATCH` never asserts and `MATCH_CNT` = 0. `LOAD_READY` = 1 during the gap, and `D` = 0 during the gap.
- **Reset mid-word:** load 0xDA and drive `RST` = 0 in cycle 5 → the next cycle shows IDLE with `D_VALID` = 0. No `DONE` occurs, `MATCH_CNT` = 0 and `LOAD_READY` = 1.
- **CLR collision:** load 0xDA and pulse `CLR` in cycle 4 (a match cycle) → `MATCH_CNT` = 0 after cycle 4. Cycle 7 does not match because the tracker restarts from S0. `MATCH_CNT` = 0 at the end of the word.
- **Saturation:** with `CNT_W` = 2, load 0xDB then 0x6D chained → 5 matches are emitted and `MATCH_CNT` holds at 3.
